// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NW_DEF = 16;
  localparam int DW_DEF = 8;

  // Quotient reported for a zero divisor at the default width.
  localparam logic [NW_DEF-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it fits.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   r,
  input  logic          q_msb,
  input  logic [DW-1:0] d,
  output logic [DW:0]   r_next,
  output logic          q_bit
);

  logic [DW:0] t;
  logic [DW:0] d_ext;
  logic        unused_r_msb;

  // R < D holds between steps, so the top bit of R is always zero and only the
  // low DW bits take part in the shift.
  assign unused_r_msb = r[DW];

  assign t     = {r[DW-1:0], q_msb};
  assign d_ext = {1'b0, d};

  // Trial subtraction decides the quotient bit and the restored remainder.
  always_comb begin
    q_bit  = (t >= d_ext);
    r_next = q_bit ? (t - d_ext) : t;
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/done handshake, zero divisor short-circuits straight to DONE.
module seq_div
  import div_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  // All-ones quotient for a zero divisor, sized to this instance.
  localparam logic [NW-1:0] DIV0_Q = '1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [NW-1:0] q_sr;
  logic [DW:0]   r_sr;
  logic [DW-1:0] d_reg;
  logic [DW:0]   r_nxt;
  logic          q_bit;
  logic          accept;
  logic          dz;
  logic          last;

  assign accept = (state == IDLE) && start;
  assign dz     = (divisor == '0);
  assign last   = (state == CALC) && (cnt == CW'(NW - 1));

  div_step #(.DW(DW)) u_step (
    .r      (r_sr),
    .q_msb  (q_sr[NW-1]),
    .d      (d_reg),
    .r_next (r_nxt),
    .q_bit  (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dz ? DONE : CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Working registers: load on accept, then shift one quotient bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sr  <= '0;
      r_sr  <= '0;
      d_reg <= '0;
      cnt   <= '0;
    end else if (accept && !dz) begin
      q_sr  <= dividend;
      d_reg <= divisor;
      r_sr  <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      q_sr  <= {q_sr[NW-2:0], q_bit};
      r_sr  <= r_nxt;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers change only when entering DONE, so they hold across idle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && dz) begin
      quotient    <= DIV0_Q;
      remainder   <= dividend[DW-1:0];
      div_by_zero <= 1'b1;
    end else if (last) begin
      quotient    <= {q_sr[NW-2:0], q_bit};
      remainder   <= r_nxt[DW-1:0];
      div_by_zero <= 1'b0;
    end
  end

endmodule
